// File: rtl/left_shift_sat_n.sv
// Signed left shift by N with saturation to BIT_OUT, as a two-stage elastic valid/ready pipeline.
// Clipped samples are flagged alongside data_out and counted in a sticky saturation counter.
module left_shift_sat_n #(
    parameter int N       = 4,
    parameter int BIT_IN  = 40,
    parameter int BIT_OUT = 40,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    input  logic [BIT_IN-1:0]  data_in,
    output logic               data_out_valid,
    input  logic               data_out_ready,
    output logic [BIT_OUT-1:0] data_out,
    output logic               sat_flag,
    input  logic               clr_count,
    output logic [CNT_W-1:0]   sat_count
);

    localparam int P = BIT_IN + N;

    // Output-range limits expressed at full product precision for a signed compare.
    localparam logic signed [P-1:0] P_MAX = {{(P-BIT_OUT+1){1'b0}}, {(BIT_OUT-1){1'b1}}};
    localparam logic signed [P-1:0] P_MIN = {{(P-BIT_OUT+1){1'b1}}, {(BIT_OUT-1){1'b0}}};
    localparam logic [BIT_OUT-1:0]  O_MAX = {1'b0, {(BIT_OUT-1){1'b1}}};
    localparam logic [BIT_OUT-1:0]  O_MIN = {1'b1, {(BIT_OUT-1){1'b0}}};

    logic                v1_q, v1_d;
    logic signed [P-1:0] p_q, p_d;
    logic                v2_q, v2_d;
    logic [BIT_OUT-1:0]  out_q, out_d;
    logic                sat_q, sat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                adv1, adv2, in_hs, out_hs;

    always_comb begin
        v1_d  = v1_q;
        p_d   = p_q;
        v2_d  = v2_q;
        out_d = out_q;
        sat_d = sat_q;
        cnt_d = cnt_q;

        adv2          = !v2_q || data_out_ready;
        adv1          = !v1_q || adv2;
        data_in_ready = rst_n && adv1;
        in_hs         = data_in_valid && data_in_ready;
        out_hs        = v2_q && data_out_ready;

        if (adv1) begin
            v1_d = in_hs;
            if (in_hs) begin
                p_d = {data_in, {N{1'b0}}};
            end
        end

        // An empty output slot drives zero data and flag.
        if (adv2) begin
            v2_d  = v1_q;
            out_d = '0;
            sat_d = 1'b0;
            if (v1_q) begin
                if (p_q > P_MAX) begin
                    out_d = O_MAX;
                    sat_d = 1'b1;
                end else if (p_q < P_MIN) begin
                    out_d = O_MIN;
                    sat_d = 1'b1;
                end else begin
                    out_d = p_q[BIT_OUT-1:0];
                end
            end
        end

        if (clr_count) begin
            cnt_d = '0;
        end else if (out_hs && sat_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            out_q <= '0;
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            out_q <= out_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the stage-1 product is pure datapath qualified by v1_q, so it needs no reset.
    always_ff @(posedge clk) begin
        p_q <= p_d;
    end

    assign data_out_valid = v2_q;
    assign data_out       = out_q;
    assign sat_flag       = sat_q;
    assign sat_count      = cnt_q;

endmodule

// File: tb/tb_left_shift_sat_n.sv
// Scoreboard bench for left_shift_sat_n (N=4, 40-bit in/out, 16-bit counter).
// Driver pushes expected samples on input handshakes; a negedge monitor pops and compares on output handshakes.
module tb_left_shift_sat_n;

    localparam int N       = 4;
    localparam int BIT_IN  = 40;
    localparam int BIT_OUT = 40;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [39:0] d;
        logic        s;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               data_in_valid;
    logic               data_in_ready;
    logic [BIT_IN-1:0]  data_in;
    logic               data_out_valid;
    logic               data_out_ready;
    logic [BIT_OUT-1:0] data_out;
    logic               sat_flag;
    logic               clr_count;
    logic [CNT_W-1:0]   sat_count;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [15:0] model_cnt;
    bit          rand_on;

    left_shift_sat_n #(.N(N), .BIT_IN(BIT_IN), .BIT_OUT(BIT_OUT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_in        (data_in),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out       (data_out),
        .sat_flag       (sat_flag),
        .clr_count      (clr_count),
        .sat_count      (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-precision multiply by 2^N, clip to the 40-bit signed range.
    function automatic exp_t model(input logic [39:0] d);
        longint v;
        longint p;
        exp_t   e;
        v = longint'($signed(d));
        p = v * 16;
        if (p > 64'sd549755813887) begin
            e.d = 40'h7F_FFFF_FFFF;
            e.s = 1'b1;
        end else if (p < -64'sd549755813888) begin
            e.d = 40'h80_0000_0000;
            e.s = 1'b1;
        end else begin
            e.d = p[39:0];
            e.s = 1'b0;
        end
        return e;
    endfunction

    task automatic send(input logic [39:0] din, input logic [39:0] ed, input logic es);
        int   n;
        exp_t e;
        e.d           = ed;
        e.s           = es;
        data_in       = din;
        data_in_valid = 1'b1;
        n             = 0;
        forever begin
            @(negedge clk);
            if (data_in_ready) begin
                sb.push_back(e);
                tick();
                break;
            end
            tick();
            n++;
            if (n > 500) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: data_in_ready stayed 0 for input 0x%0h", din);
                break;
            end
        end
        data_in_valid = 1'b0;
        data_in       = '0;
    endtask

    // Monitor: output handshakes, stall stability, idle zeros and the saturation counter model.
    initial begin
        logic        pst;
        logic [39:0] pd;
        logic        ps;
        logic        hs;
        logic        hs_sat;
        exp_t        e;
        pst       = 1'b0;
        pd        = '0;
        ps        = 1'b0;
        model_cnt = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                model_cnt = '0;
                pst       = 1'b0;
            end else begin
                check("sat_count", 64'(sat_count), 64'(model_cnt));
                if (pst) begin
                    check("stall_valid", 64'(data_out_valid), 64'd1);
                    check("stall_data", 64'(data_out), 64'(pd));
                    check("stall_flag", 64'(sat_flag), 64'(ps));
                end
                if (!data_out_valid) begin
                    check("idle_data", 64'(data_out), 64'd0);
                    check("idle_flag", 64'(sat_flag), 64'd0);
                end
                hs     = data_out_valid && data_out_ready;
                hs_sat = 1'b0;
                if (hs) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got 0x%0h with no sample outstanding", data_out);
                    end else begin
                        e      = sb.pop_front();
                        hs_sat = e.s;
                        check("out_data", 64'(data_out), 64'(e.d));
                        check("out_flag", 64'(sat_flag), 64'(e.s));
                    end
                end
                if (clr_count) begin
                    model_cnt = '0;
                end else if (hs_sat && model_cnt != 16'hFFFF) begin
                    model_cnt = model_cnt + 16'd1;
                end
                pst = data_out_valid && !data_out_ready;
                pd  = data_out;
                ps  = sat_flag;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] d;
        exp_t        e;
        int          n;
        rst_n          = 1'b0;
        data_in_valid  = 1'b0;
        data_in        = '0;
        data_out_ready = 1'b0;
        clr_count      = 1'b0;
        rand_on        = 1'b0;
        repeat (3) tick();
        check("rst_valid", 64'(data_out_valid), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_flag", 64'(sat_flag), 64'd0);
        check("rst_count", 64'(sat_count), 64'd0);
        check("rst_in_ready", 64'(data_in_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        data_out_ready = 1'b1;

        // Basic shift and latency.
        send(40'h00_0000_0003, 40'h00_0000_0030, 1'b0);
        check("lat_e0_valid", 64'(data_out_valid), 64'd0);
        tick();
        check("lat_e1_valid", 64'(data_out_valid), 64'd1);
        check("lat_e1_data", 64'(data_out), 64'h30);

        // Negative, boundary and saturating samples, back to back.
        send(40'hFF_FFFF_FFFB, 40'hFF_FFFF_FFB0, 1'b0);
        send(40'h07_FFFF_FFFF, 40'h7F_FFFF_FFF0, 1'b0);
        send(40'hF8_0000_0000, 40'h80_0000_0000, 1'b0);
        send(40'h08_0000_0000, 40'h7F_FFFF_FFFF, 1'b1);
        send(40'hF7_FFFF_FFFF, 40'h80_0000_0000, 1'b1);
        send(40'h80_0000_0000, 40'h80_0000_0000, 1'b1);
        repeat (4) tick();
        check("sat_count_3", 64'(sat_count), 64'd3);

        // Clear coincident with a saturating handshake wins.
        data_out_ready = 1'b0;
        send(40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFF, 1'b1);
        tick();
        check("clr_pre_valid", 64'(data_out_valid), 64'd1);
        clr_count      = 1'b1;
        data_out_ready = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_priority", 64'(sat_count), 64'd0);

        // Backpressure: two samples buffered, third blocked, FIFO release.
        data_out_ready = 1'b0;
        fork
            begin
                send(40'h1, 40'h10, 1'b0);
                send(40'h2, 40'h20, 1'b0);
                send(40'h3, 40'h30, 1'b0);
            end
            begin
                repeat (5) tick();
                check("stall_in_ready", 64'(data_in_ready), 64'd0);
                check("stall_out_valid", 64'(data_out_valid), 64'd1);
                check("stall_out_hold", 64'(data_out), 64'h10);
                data_out_ready = 1'b1;
            end
        join
        repeat (5) tick();
        check("stall_drained", 64'(sb.size()), 64'd0);

        // Random valid gaps and ready pattern against the reference model.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    d = {8'($urandom), 32'($urandom)};
                    if ($urandom_range(0, 1) == 1) d = 40'($signed(d) >>> 6);
                    e = model(d);
                    send(d, e.d, e.s);
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    data_out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        data_out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("rand_drained", 64'(sb.size()), 64'd0);

        // Reset with two samples in flight.
        send(40'h10_0000_0000, 40'h7F_FFFF_FFFF, 1'b1);
        repeat (3) tick();
        check("pre_rst_count_nz", 64'(sat_count != 0), 64'd1);
        data_out_ready = 1'b0;
        send(40'h5, 40'h50, 1'b0);
        send(40'h6, 40'h60, 1'b0);
        check("pre_rst_valid", 64'(data_out_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 64'(data_out_valid), 64'd0);
        check("mid_rst_data", 64'(data_out), 64'd0);
        check("mid_rst_flag", 64'(sat_flag), 64'd0);
        check("mid_rst_count", 64'(sat_count), 64'd0);
        check("mid_rst_in_ready", 64'(data_in_ready), 64'd0);
        rst_n          = 1'b1;
        data_out_ready = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", 64'(data_out_valid), 64'd0);
        send(40'h7, 40'h70, 1'b0);
        repeat (4) tick();
        check("post_rst_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
